// File: rtl/arb_mux_pkg.sv
// Shared helpers for arb_mux_reg: rotating find-first grant and one-hot encode.
// Functions work on MAX_CH-wide vectors; callers zero-extend and slice.
package arb_mux_pkg;

    localparam int unsigned MAX_CH   = 32;
    localparam int unsigned MAX_CH_W = 5;

    // One-hot grant for the first set bit of req, searching from ptr upward and wrapping mod ch.
    function automatic logic [MAX_CH-1:0] rr_find_first(
        input logic [MAX_CH-1:0] req,
        input int unsigned       ptr,
        input int unsigned       ch
    );
        logic [MAX_CH-1:0] gnt;
        int unsigned       idx;
        gnt = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            if (k < ch) begin
                idx = ptr + k;
                if (idx >= ch) begin
                    idx = idx - ch;
                end
                if (req[idx[MAX_CH_W-1:0]] && (gnt == '0)) begin
                    gnt[idx[MAX_CH_W-1:0]] = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

    // Index of the set bit in a one-hot vector (0 when none set).
    function automatic logic [MAX_CH_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
        logic [MAX_CH_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            if (oh[k]) begin
                idx = k[MAX_CH_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Round-robin arbiter owning the rotation pointer.
// Macro ARB_MUX_FIXED_PRIO_EN: pointer held at 0, giving fixed lowest-index priority.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int unsigned CH   = 4,
    localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   req,
    input  logic            advance,
    output logic [CH-1:0]   grant,
    output logic [CH_W-1:0] grant_idx
);

    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [MAX_CH-1:0]   req_ext, gnt_ext;
    logic [MAX_CH_W-1:0] idx_ext;

    // Rotating search from the pointer; grant and its encoded index.
    always_comb begin
        req_ext           = '0;
        req_ext[CH-1:0]   = req;
        gnt_ext           = rr_find_first(req_ext, 32'(ptr_q), CH);
        idx_ext           = onehot_to_idx(gnt_ext);
        grant             = gnt_ext[CH-1:0];
        grant_idx         = idx_ext[CH_W-1:0];
    end

    // Next pointer: one past the granted channel on each accepted transfer.
    always_comb begin
        ptr_d = ptr_q;
`ifdef ARB_MUX_FIXED_PRIO_EN
        ptr_d = '0;
`else
        if (advance && (grant != '0)) begin
            if (grant_idx == CH_W'(CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
`endif
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// CH-channel arbitrated mux with a one-entry registered output and valid/ready on all ports.
// Macro ARB_MUX_FIXED_PRIO_EN (in rr_arbiter): fixed priority instead of round-robin.
module arb_mux_reg
    import arb_mux_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned CH   = 4,
    localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH*N-1:0] in_data,
    output logic [CH-1:0]   in_ready,
    output logic            out_valid,
    output logic [N-1:0]    out_data,
    output logic [CH_W-1:0] out_ch,
    input  logic            out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [CH-1:0]   grant;
    logic [CH_W-1:0] grant_idx;
    logic            can_load, load;
    logic [N-1:0]    sel_data;

    rr_arbiter #(.CH(CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: load when a channel is granted and the output slot is free or draining.
    always_comb begin
        can_load = !out_valid_q || out_ready;
        load     = (grant != '0) && can_load;
        in_ready = grant & {CH{can_load & rst_n}};
        sel_data = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*N +: N];
            end
        end
    end

    // Output register next state: load, drain or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Scoreboard bench for arb_mux_reg (N=16, CH=4); expected transfers are queued by the stimulus
// and popped by a monitor whenever the DUT completes an output handshake.
module tb_arb_mux_reg;

    localparam int unsigned N    = 16;
    localparam int unsigned CH   = 4;
    localparam int unsigned CH_W = 2;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [N-1:0]    data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   in_valid;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_ready;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic [CH_W-1:0] out_ch;
    logic            out_ready;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    arb_mux_reg #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int unsigned ch);
        exp_t e;
        e.ch   = CH_W'(ch);
        e.data = N'(16'h00A0 + ch);
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    // Monitor: every completed output handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", {30'b0, out_ch}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_ch", 32'(out_ch), 32'(e.ch));
                    chk("out_data", 32'(out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(CH); i++) begin
            in_data[i*N +: N] = N'(16'h00A0 + i);
        end
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;

        // 1. reset state with all channels requesting
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
`ifdef ARB_MUX_FIXED_PRIO_EN
            push(0);
`else
            push(k % 4);
`endif
        end
        @(negedge clk);
        chk("first_grant", 32'(in_ready), 32'h1);
        // 2. continuous requests, eight back-to-back transfers
        repeat (8) @(posedge clk);
        #1;
        in_valid = '0;
        settle();

`ifdef ARB_MUX_FIXED_PRIO_EN
        // 6. fixed priority: ch0 always wins over ch3 until it drops
        in_valid = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            push(0);
            @(negedge clk);
            chk("fixed_in_ready", 32'(in_ready), 32'h1);
            step();
        end
        in_valid = 4'b1000;
        push(3);
        @(negedge clk);
        chk("fixed_ch3_ready", 32'(in_ready), 32'h8);
        step();
        settle();
`else
        // 3. backpressure for three cycles, then resume with next channel, no bubble
        in_valid  = '1;
        out_ready = 1'b1;
        push(0);
        push(1);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_ch", 32'(out_ch), 32'd0);
            chk("stall_data", 32'(out_data), 32'h00A0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_in_ready", 32'(in_ready), 32'h2);
        step();
        in_valid = '0;
        @(negedge clk);
        chk("resume_no_bubble", 32'(out_valid), 32'd1);
        settle();

        // 4. sparse requests: ch2 alone, then ch1+ch3 with pointer at 3
        in_valid = 4'b0100;
        push(2);
        @(negedge clk);
        chk("sparse_ch2", 32'(in_ready), 32'h4);
        step();
        in_valid = 4'b1010;
        push(3);
        push(1);
        @(negedge clk);
        chk("sparse_ch3", 32'(in_ready), 32'h8);
        step();
        @(negedge clk);
        chk("sparse_wrap_ch1", 32'(in_ready), 32'h2);
        step();
        settle();

        // 5. asynchronous reset during a stall; pointer sits at 2 beforehand
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        step();
        in_valid = '0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_ch", 32'(out_ch), 32'd1);
        #2;
        rst_n    = 1'b0;
        in_valid = '1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_reemit", 32'(out_valid), 32'd0);
        end
        step();
        in_valid = 4'b0110;
        push(1);
        @(negedge clk);
        chk("post_rst_ptr0", 32'(in_ready), 32'h2);
        step();
        settle();
`endif

        repeat (3) step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
